// File: rtl/gpu_instruction_encoder.sv
// Sequences one host draw request into the XY1/XY2/RAD/DRAW instruction stream, honouring stall_i.
// Optional macro GPU_ENC_XY_CACHE_EN: skip setup instructions that repeat the last issued value.
module gpu_instruction_encoder #(
  parameter int unsigned WIDTH_BITS   = 10,
  parameter int unsigned HEIGHT_BITS  = 9,
  parameter int unsigned CHANNEL_BITS = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [3:0]              req_op_i,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic [WIDTH_BITS-1:0]   rad_i,
  input  logic [2:0]              oct_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic                    stall_i,
  output logic [3:0]              opcode_o,
  output logic [27:0]             parameters_o,
  output logic                    command_o,
  output logic                    busy_o,
  output logic                    illegal_o
);

  localparam int unsigned XY_BITS  = WIDTH_BITS + HEIGHT_BITS;
  localparam int unsigned RGB_BITS = 3 * CHANNEL_BITS;

  typedef enum logic [2:0] {IDLE, XY1, XY2, RAD, DRAW} state_t;

  state_t state_q, state_d, eff_state;

  logic [3:0]            op_q;
  logic [XY_BITS-1:0]    xy1_q, xy2_q;
  logic [WIDTH_BITS-1:0] rad_q;
  logic [2:0]            oct_q;
  logic [RGB_BITS-1:0]   rgb_q;

  logic [3:0]  opcode_q, opcode_d;
  logic [27:0] params_q, params_d;
  logic        command_q, command_d;
  logic        illegal_q, illegal_d;

  logic        accept, op_legal, round_op;
  logic [27:0] draw_p;

  assign accept   = req_valid_i && (state_q == IDLE);
  assign op_legal = (req_op_i >= 4'd4) && (req_op_i <= 4'd8);
  assign round_op = (op_q == 4'd6) || (op_q == 4'd7);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      op_q  <= '0;
      xy1_q <= '0;
      xy2_q <= '0;
      rad_q <= '0;
      oct_q <= '0;
      rgb_q <= '0;
    end else if (accept) begin
      op_q  <= req_op_i;
      xy1_q <= {y1_i, x1_i};
      xy2_q <= {y2_i, x2_i};
      rad_q <= rad_i;
      oct_q <= oct_i;
      rgb_q <= {r_i, g_i, b_i};
    end
  end

  always_comb begin
    draw_p = 28'(rgb_q);
    if (op_q == 4'd7) draw_p[26:24] = oct_q;
    if (op_q == 4'd8) draw_p = '0;
  end

`ifdef GPU_ENC_XY_CACHE_EN
  logic [XY_BITS-1:0]    c_xy1_q, c_xy2_q;
  logic [WIDTH_BITS-1:0] c_rad_q;
  logic                  c_xy1_v_q, c_xy2_v_q, c_rad_v_q;
  logic                  hit_xy1, hit_xy2, hit_rad;

  assign hit_xy1 = c_xy1_v_q && (c_xy1_q == xy1_q);
  assign hit_xy2 = c_xy2_v_q && (c_xy2_q == xy2_q);
  assign hit_rad = c_rad_v_q && (c_rad_q == rad_q);

  // Cached setup states are walked through combinationally so a hit costs no cycle.
  always_comb begin
    eff_state = state_q;
    if (eff_state == XY1 && hit_xy1) eff_state = round_op ? RAD : XY2;
    if (eff_state == XY2 && hit_xy2) eff_state = DRAW;
    if (eff_state == RAD && hit_rad) eff_state = DRAW;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      c_xy1_q   <= '0;
      c_xy2_q   <= '0;
      c_rad_q   <= '0;
      c_xy1_v_q <= 1'b0;
      c_xy2_v_q <= 1'b0;
      c_rad_v_q <= 1'b0;
    end else if (command_d) begin
      if (eff_state == XY1) begin
        c_xy1_q   <= xy1_q;
        c_xy1_v_q <= 1'b1;
      end
      if (eff_state == XY2) begin
        c_xy2_q   <= xy2_q;
        c_xy2_v_q <= 1'b1;
      end
      if (eff_state == RAD) begin
        c_rad_q   <= rad_q;
        c_rad_v_q <= 1'b1;
      end
    end
  end
`else
  assign eff_state = state_q;
`endif

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    params_d  = params_q;
    command_d = 1'b0;
    illegal_d = 1'b0;
    case (eff_state)
      IDLE: begin
        if (req_valid_i) begin
          if (op_legal) state_d = (req_op_i == 4'd8) ? DRAW : XY1;
          else          illegal_d = 1'b1;
        end
      end
      XY1: begin
        if (!stall_i) begin
          command_d = 1'b1;
          opcode_d  = 4'd1;
          params_d  = 28'(xy1_q);
          state_d   = round_op ? RAD : XY2;
        end
      end
      XY2: begin
        if (!stall_i) begin
          command_d = 1'b1;
          opcode_d  = 4'd2;
          params_d  = 28'(xy2_q);
          state_d   = DRAW;
        end
      end
      RAD: begin
        if (!stall_i) begin
          command_d = 1'b1;
          opcode_d  = 4'd3;
          params_d  = 28'(rad_q);
          state_d   = DRAW;
        end
      end
      DRAW: begin
        if (!stall_i) begin
          command_d = 1'b1;
          opcode_d  = op_q;
          params_d  = draw_p;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      params_q  <= '0;
      command_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      params_q  <= params_d;
      command_q <= command_d;
      illegal_q <= illegal_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign opcode_o     = opcode_q;
  assign parameters_o = params_q;
  assign command_o    = command_q;
  assign illegal_o    = illegal_q;

endmodule
